hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for deeper successors of the 3-stage RV32 core. It tracks every in-flight destination register between the decode/execute stage (ID/EX) and write-back across STAGES result stages. It produces per-operand forward selects, RAW/load-use stalls, fetch/decode flush, and a start/done handshake with a multicycle execution unit. It replaces the combinational forwarding unit; the result-stage pipeline registers and the forward muxes stay outside this block.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_ctrl_if.sv | 39 +++
 rtl/hazard_match.sv | 36 +++
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/forwarding controller.
// Slot records, multicycle FSM states and forward-select sizing.
package hazard_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned FWD_RF = 0;

  // One in-flight result slot; the rd field width follows REG_W.
  typedef struct packed {
    logic             valid;
    logic             we;
    logic             load;
    logic [REG_W-1:0] rd;
  } slot_t;

  typedef enum logic [0:0] {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

  function automatic int unsigned fwd_w(input int unsigned stages);
    fwd_w = $clog2(stages + 32'd1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side hazard interface: ID/EX instruction info in, stall/flush/forward out.
interface hazard_ctrl_if
  import hazard_pkg::*;
#(
  parameter int unsigned REGW = REG_W,
  parameter int unsigned FW   = 2
) ();

  logic            issue_valid_i;
  logic [REGW-1:0] rs1_i;
  logic [REGW-1:0] rs2_i;
  logic            rs1_used_i;
  logic            rs2_used_i;
  logic [REGW-1:0] rd_i;
  logic            rd_we_i;
  logic            is_load_i;
  logic            is_mc_i;
  logic            mc_done_i;
  logic            redirect_i;
  logic            stall_fd_o;
  logic            flush_fd_o;
  logic            mc_start_o;
  logic [FW-1:0]   fwd_a_o;
  logic [FW-1:0]   fwd_b_o;
  logic [FW-1:0]   inflight_o;

  modport master (
    output issue_valid_i, rs1_i, rs2_i, rs1_used_i, rs2_used_i,
           rd_i, rd_we_i, is_load_i, is_mc_i, mc_done_i, redirect_i,
    input  stall_fd_o, flush_fd_o, mc_start_o, fwd_a_o, fwd_b_o, inflight_o
  );

  modport slave (
    input  issue_valid_i, rs1_i, rs2_i, rs1_used_i, rs2_used_i,
           rd_i, rd_we_i, is_load_i, is_mc_i, mc_done_i, redirect_i,
    output stall_fd_o, flush_fd_o, mc_start_o, fwd_a_o, fwd_b_o, inflight_o
  );

endinterface

// File: rtl/hazard_match.sv
// Per-operand youngest-match priority encoder over the in-flight result slots.
// Produces a forward select, or a stall when the youngest producer is a not-yet-ready load.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int unsigned REGW       = REG_W,
  parameter int unsigned STAGES     = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned FW         = fwd_w(STAGES)
) (
  input  logic                i_used,
  input  logic [REGW-1:0]     i_rs,
  input  slot_t [STAGES:1]    i_slot,
  output logic [FW-1:0]       o_fwd_c,
  output logic                o_stall_c
);

  // Walk oldest to youngest so the youngest match is the last one written.
  always_comb begin
    o_fwd_c   = FW'(FWD_RF);
    o_stall_c = 1'b0;
    for (int unsigned k = STAGES; k >= 1; k--) begin
      if (i_used && (i_rs != '0) && i_slot[k].valid && i_slot[k].we &&
          (i_slot[k].rd == i_rs)) begin
        if (!i_slot[k].load || (k >= LOAD_STAGE)) begin
          o_fwd_c   = FW'(k);
          o_stall_c = 1'b0;
        end else begin
          o_fwd_c   = FW'(FWD_RF);
          o_stall_c = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller: tracks in-flight destinations across STAGES result
// slots and drives forward selects, RAW/load-use/multicycle stalls and fetch flush.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REGW       = REG_W,
  parameter int unsigned STAGES     = 3,
  parameter int unsigned LOAD_STAGE = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  hazard_ctrl_if.slave  bus
);

  localparam int unsigned FW = fwd_w(STAGES);

  slot_t [STAGES:1] r_slot;
  slot_t [STAGES:1] w_slot_nxt;
  logic [FW-1:0]    r_inflight;
  logic [FW-1:0]    w_inflight_nxt;
  mc_state_e        r_state;
  mc_state_e        w_state_nxt;

  logic             w_issue_c;
  logic [FW-1:0]    w_fwd_a_c;
  logic [FW-1:0]    w_fwd_b_c;
  logic             w_stall_a_c;
  logic             w_stall_b_c;
  logic             w_raw_stall_c;
  logic             w_mc_start_c;
  logic             w_mc_hold_c;
  logic             w_stall_c;

  // Reset gates every combinational output, so nothing leaks out while rst_i is low.
  assign w_issue_c = bus.issue_valid_i & rst_i;

  hazard_match #(
    .REGW       (REGW),
    .STAGES     (STAGES),
    .LOAD_STAGE (LOAD_STAGE),
    .FW         (FW)
  ) u_match_a (
    .i_used    (bus.rs1_used_i),
    .i_rs      (bus.rs1_i),
    .i_slot    (r_slot),
    .o_fwd_c   (w_fwd_a_c),
    .o_stall_c (w_stall_a_c)
  );

  hazard_match #(
    .REGW       (REGW),
    .STAGES     (STAGES),
    .LOAD_STAGE (LOAD_STAGE),
    .FW         (FW)
  ) u_match_b (
    .i_used    (bus.rs2_used_i),
    .i_rs      (bus.rs2_i),
    .i_slot    (r_slot),
    .o_fwd_c   (w_fwd_b_c),
    .o_stall_c (w_stall_b_c)
  );

  assign w_raw_stall_c = w_issue_c & (w_stall_a_c | w_stall_b_c);

  // Multicycle FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= MC_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Multicycle next state: one start pulse per instruction, hold until the done pulse.
  always_comb begin
    w_state_nxt  = r_state;
    w_mc_start_c = 1'b0;
    w_mc_hold_c  = 1'b0;
    case (r_state)
      MC_IDLE: begin
        if (w_issue_c && bus.is_mc_i && !w_raw_stall_c) begin
          w_mc_start_c = 1'b1;
          w_state_nxt  = MC_BUSY;
        end
      end
      MC_BUSY: begin
        if (bus.mc_done_i) begin
          w_state_nxt = MC_IDLE;
        end else begin
          w_mc_hold_c = 1'b1;
        end
      end
      default: w_state_nxt = MC_IDLE;
    endcase
  end

  assign w_stall_c = w_raw_stall_c | w_mc_start_c | w_mc_hold_c;

  // Next slot contents: shift toward write-back, slot 1 takes the issuing instruction or a bubble.
  always_comb begin
    w_slot_nxt = r_slot;
    for (int unsigned k = 2; k <= STAGES; k++) begin
      w_slot_nxt[k] = r_slot[k-1];
    end
    w_slot_nxt[1] = '0;
    if (w_issue_c && !w_stall_c) begin
      w_slot_nxt[1].valid = 1'b1;
      w_slot_nxt[1].we    = bus.rd_we_i && (bus.rd_i != '0);
      w_slot_nxt[1].load  = bus.is_load_i;
      w_slot_nxt[1].rd    = bus.rd_i;
    end
  end

  always_comb begin
    w_inflight_nxt = '0;
    for (int unsigned k = 1; k <= STAGES; k++) begin
      w_inflight_nxt = w_inflight_nxt + FW'(w_slot_nxt[k].valid & w_slot_nxt[k].we);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_slot     <= '0;
      r_inflight <= '0;
    end else begin
      r_slot     <= w_slot_nxt;
      r_inflight <= w_inflight_nxt;
    end
  end

  assign bus.stall_fd_o = w_stall_c;
  assign bus.flush_fd_o = bus.redirect_i & w_issue_c & ~w_stall_c;
  assign bus.mc_start_o = w_mc_start_c;
  assign bus.fwd_a_o    = w_issue_c ? w_fwd_a_c : FW'(FWD_RF);
  assign bus.fwd_b_o    = w_issue_c ? w_fwd_b_c : FW'(FWD_RF);
  assign bus.inflight_o = r_inflight;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver queues hand-computed per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int unsigned FW = 2;

  typedef struct {
    logic [8:0] v;
    bit         chk1;
    logic [8:0] v1;
    string      name;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  hazard_ctrl_if #(.REGW(5), .FW(FW)) bus0 ();
  hazard_ctrl_if #(.REGW(5), .FW(FW)) bus1 ();

  hazard_ctrl #(.REGW(5), .STAGES(3), .LOAD_STAGE(2)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus0)
  );

  hazard_ctrl #(.REGW(5), .STAGES(3), .LOAD_STAGE(1)) dut_l1 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus1)
  );

  assign bus1.issue_valid_i = bus0.issue_valid_i;
  assign bus1.rs1_i         = bus0.rs1_i;
  assign bus1.rs2_i         = bus0.rs2_i;
  assign bus1.rs1_used_i    = bus0.rs1_used_i;
  assign bus1.rs2_used_i    = bus0.rs2_used_i;
  assign bus1.rd_i          = bus0.rd_i;
  assign bus1.rd_we_i       = bus0.rd_we_i;
  assign bus1.is_load_i     = bus0.is_load_i;
  assign bus1.is_mc_i       = bus0.is_mc_i;
  assign bus1.mc_done_i     = bus0.mc_done_i;
  assign bus1.redirect_i    = bus0.redirect_i;

  always #5 clk_i = ~clk_i;

  function automatic logic [8:0] ev(input logic s, input logic f, input logic m,
                                    input logic [1:0] a, input logic [1:0] b,
                                    input logic [1:0] n);
    return {s, f, m, a, b, n};
  endfunction

  // Drive one cycle of inputs, queue the expected outputs, advance past the next edge.
  task automatic cyc(input logic rst, input logic iv,
                     input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd, input logic we, input logic ld,
                     input logic mc, input logic done, input logic redir,
                     input logic [8:0] e, input string name,
                     input bit chk1 = 1'b0, input logic [8:0] e1 = '0);
    exp_t x;
    rst_i              = rst;
    bus0.issue_valid_i = iv;
    bus0.rs1_i         = rs1;
    bus0.rs1_used_i    = u1;
    bus0.rs2_i         = rs2;
    bus0.rs2_used_i    = u2;
    bus0.rd_i          = rd;
    bus0.rd_we_i       = we;
    bus0.is_load_i     = ld;
    bus0.is_mc_i       = mc;
    bus0.mc_done_i     = done;
    bus0.redirect_i    = redir;
    x.v    = e;
    x.chk1 = chk1;
    x.v1   = e1;
    x.name = name;
    exp_q.push_back(x);
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: outputs are valid every cycle, so one queued entry is consumed per negedge.
  initial begin
    exp_t       e;
    logic [8:0] act;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {bus0.stall_fd_o, bus0.flush_fd_o, bus0.mc_start_o,
               bus0.fwd_a_o, bus0.fwd_b_o, bus0.inflight_o};
        n_chk++;
        if (act === e.v) n_pass++;
        else $display("FAIL %s: got stall/flush/start/fa/fb/inflight=%b want %b",
                      e.name, act, e.v);
        if (e.chk1) begin
          act = {bus1.stall_fd_o, bus1.flush_fd_o, bus1.mc_start_o,
                 bus1.fwd_a_o, bus1.fwd_b_o, bus1.inflight_o};
          n_chk++;
          if (act === e.v1) n_pass++;
          else $display("FAIL %s_l1: got stall/flush/start/fa/fb/inflight=%b want %b",
                        e.name, act, e.v1);
        end
      end
    end
  end

  initial begin
    @(posedge clk_i);
    #1;
    //  rst iv rs1 u rs2 u rd we ld mc dn rd  expected
    cyc(0, 1, 5, 1, 0, 0, 9, 1, 0, 1, 0, 0, ev(0,0,0,0,0,0), "reset_idle");
    cyc(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, ev(0,0,0,0,0,0), "alu_issue_x5");
    cyc(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, ev(0,0,0,1,0,1), "alu_fwd_slot1");
    cyc(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, ev(0,0,0,2,0,1), "alu_fwd_slot2");
    cyc(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, ev(0,0,0,3,0,1), "alu_fwd_wb");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev(0,0,0,0,0,0), "drained");
    cyc(1, 1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, ev(0,0,0,0,0,0), "load_x6");
    cyc(1, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, ev(1,0,0,0,0,1), "load_use_stall",
        1'b1, ev(0,0,0,0,1,1));
    cyc(1, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, ev(0,0,0,0,2,1), "load_use_fwd2");
    cyc(1, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, ev(0,0,0,0,0,1), "no_issue_fwd0");
    cyc(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, ev(0,0,0,0,0,0), "x7_first");
    cyc(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, ev(0,0,0,0,0,1), "x7_second");
    cyc(1, 1, 7, 1, 0, 0, 0, 1, 0, 0, 0, 0, ev(0,0,0,1,0,2), "youngest_wins");
    cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, ev(0,0,0,0,0,2), "x0_no_match");
    cyc(1, 1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, ev(1,0,1,0,0,1), "mc_start");
    cyc(1, 1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, ev(1,0,0,0,0,0), "mc_busy1");
    cyc(1, 1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, ev(1,0,0,0,0,0), "mc_busy2");
    cyc(1, 1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, ev(1,0,0,0,0,0), "mc_busy3");
    cyc(1, 1, 0, 0, 0, 0, 9, 1, 0, 1, 1, 0, ev(0,0,0,0,0,0), "mc_done");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ev(0,0,0,0,0,1), "mc_retired_x9");
    cyc(1, 1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, ev(0,0,0,0,0,1), "redir_load");
    cyc(1, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 1, ev(1,0,0,0,0,2), "redir_deferred");
    cyc(1, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 1, ev(0,1,0,0,2,1), "redir_flush");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev(0,0,0,0,0,1), "redir_done");
    cyc(1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, ev(0,0,0,0,0,0), "fill_x1");
    cyc(1, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, ev(0,0,0,0,0,1), "fill_x2");
    cyc(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, ev(0,0,0,0,0,2), "fill_x3");
    cyc(1, 1, 3, 1, 0, 0, 4, 1, 0, 1, 0, 0, ev(1,0,1,1,0,3), "mc2_start");
    cyc(1, 1, 3, 1, 0, 0, 4, 1, 0, 1, 0, 0, ev(1,0,0,2,0,2), "mc2_busy");
    cyc(0, 1, 3, 1, 0, 0, 4, 1, 0, 1, 0, 0, ev(0,0,0,0,0,0), "reset_mid_busy");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ev(0,0,0,0,0,0), "done_ignored");
    cyc(1, 1, 3, 1, 2, 1, 5, 1, 0, 0, 0, 0, ev(0,0,0,0,0,0), "post_reset_clean");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev(0,0,0,0,0,1), "post_reset_x5");
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk_i);
    if (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
